apple_video_fetch: RTL
======================

APPLE_VIDEO_FETCH -- requirements
Module: apple_video_fetch

Interface
REQ-001 SHALL have ports clk_logic, in, 1, the single clock; all logic on its rising edge.
REQ-002 SHALL have port reset, in, 1, an asynchronous active-high reset.
REQ-003 SHALL have port line_start_i, in, 1, a one-cycle request to fetch one scanline.
REQ-004 SHALL have port line_i, in, 8, the scanline number 0..191.
REQ-005 SHALL have ports text_mode_i, mixed_mode_i, hires_mode_i, page2_i and store80_i, in, 1 each, the display soft switches.
REQ-006 SHALL have port video_address_o, out, 16, the shadow-memory read address; it is always even.
REQ-007 SHALL have port video_rd_o, out, 1, the read strobe.
REQ-008 SHALL have port video_data_i, in, 32, the read data {aux1,main1,aux0,main0} for addresses A and A+1, valid one cycle after video_rd_o.
REQ-009 SHALL have ports buf_addr_i (in, 5) and buf_data_o (out, 32), the combinational line-buffer read port for words 0..19.
REQ-010 SHALL have ports busy_o (out, 1), line_done_o (out, 1, one-cycle pulse), overrun_o (out, 1, sticky) and is_text_o (out, 1, line mode of the readable buffer).

Function
REQ-011 SHALL use states IDLE, ISSUE, DRAIN and DONE: IDLE goes to ISSUE on an accepted line_start_i; ISSUE goes to DRAIN after 20 reads; DRAIN goes to DONE; DONE goes to IDLE.
REQ-012 SHALL, on acceptance, latch line_i and all soft-switch inputs; input changes during a fetch SHALL have no effect.
REQ-013 SHALL fetch text when text_mode_i=1, or when mixed_mode_i=1 and line>=160, or when hires_mode_i=0; otherwise hires.
REQ-014 SHALL use effective page2 = page2_i AND NOT store80_i.
REQ-015 SHALL compute the text base as 0x0400 + 0x80*(r mod 8) + 0x28*(r div 8), with r = line div 8, plus 0x0400 if effective page2 is set.
REQ-016 SHALL compute the hires base as 0x2000 + 0x400*(line mod 8) + 0x80*((line div 8) mod 8) + 0x28*(line div 64), plus 0x2000 if effective page2 is set; all arithmetic is 16-bit with no wrap in range.
REQ-017 SHALL, in ISSUE, assert video_rd_o for 20 consecutive cycles at addresses base+2k, k=0..19, with the first read one cycle after acceptance.
REQ-018 SHALL write video_data_i into buffer word k one cycle after read k; the last capture occurs in DRAIN.
REQ-019 SHALL assert busy_o in ISSUE, DRAIN and DONE.
REQ-020 SHALL pulse line_done_o in DONE, i.e. 22 cycles after the line_start_i cycle.
REQ-021 SHALL, on line_start_i while busy_o=1, ignore the request, set overrun_o, and leave the current fetch undisturbed.
REQ-022 SHALL ignore line_start_i with line_i>=192: no reads, no line_done_o, overrun_o unchanged.
REQ-023 SHALL hold video_rd_o=0 and video_address_o unchanged outside ISSUE.
REQ-024 SHALL accept a line_start_i arriving in the same cycle as DONE's return to IDLE on the following cycle only (IDLE-only acceptance).

Reset
REQ-025 SHALL, on reset, set state=IDLE, video_rd_o=0, video_address_o=0x0000, busy_o=0, line_done_o=0, overrun_o=0, is_text_o=0, the write bank to 0 and all buffer words to 0.
REQ-026 SHALL, on reset during a fetch, abort immediately with no line_done_o; the partial line SHALL be cleared.

Configuration
REQ-027 SHALL, when APPLE_VIDEO_FETCH_DOUBLE_BUFFER_EN is defined, keep two 20-word banks: the fetch writes one bank, buf_data_o reads the other, and the banks and is_text_o swap in DONE.
REQ-028 SHALL, without APPLE_VIDEO_FETCH_DOUBLE_BUFFER_EN, keep a single bank in which buf_data_o reads words as they are written, and update is_text_o in DONE.

Verification
REQ-029 SHALL test: line 0, text, page1 -> addresses 0x0400,0x0402..0x0426; line_done_o 22 cycles after the start.
REQ-030 SHALL test: line 1, hires, page1 -> first address 0x2400, last 0x2426.
REQ-031 SHALL test: line 191, hires, page2=1, store80=0 -> first address 0x5FD0; with store80=1 -> 0x3FD0.
REQ-032 SHALL test: line 160, hires, mixed=1 -> text base 0x0650; is_text_o=1 after the swap.
REQ-033 SHALL test: line_start_i at cycle 5 of a fetch -> exactly 20 reads, overrun_o=1, a single line_done_o.
REQ-034 SHALL test: reset asserted at read 10, then a new start on line 8 -> no line_done_o for the aborted fetch, the buffer cleared, and a clean 0x0480 fetch.

Source files
------------

// File: rtl/apple_video_fetch.sv
`default_nettype none
// ============================================================================
// Module   : apple_video_fetch
// Purpose  : Fetches one Apple II scanline (20 x 32-bit words, i.e. 40 byte
//            pairs of main/aux memory) from shadow memory into a line buffer.
//            The start address is derived from the scanline number and the
//            display soft switches, using either text or hires interleaving.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_logic        in   1  single clock, rising edge
//   reset            in   1  asynchronous active-high reset
//   line_start_i     in   1  one-cycle request to fetch a scanline
//   line_i           in   8  scanline number 0..191
//   text_mode_i      in   1  soft switch TEXT
//   mixed_mode_i     in   1  soft switch MIXED
//   hires_mode_i     in   1  soft switch HIRES
//   page2_i          in   1  soft switch PAGE2
//   store80_i        in   1  soft switch 80STORE
//   video_address_o  out 16  shadow-memory read address (always even)
//   video_rd_o       out  1  read strobe
//   video_data_i     in  32  {aux1,main1,aux0,main0}, valid 1 cycle after rd
//   buf_addr_i       in   5  line-buffer read word 0..19
//   buf_data_o       out 32  line-buffer read data (combinational)
//   busy_o           out  1  fetch in progress
//   line_done_o      out  1  one-cycle pulse when the line is complete
//   overrun_o        out  1  sticky: a start arrived while busy
//   is_text_o        out  1  line mode of the readable buffer
// ----------------------------------------------------------------------------
// Build option
//   APPLE_VIDEO_FETCH_DOUBLE_BUFFER_EN : two banks; the fetch fills one while
//   buf_data_o reads the other, swapping when the line completes. Without it
//   a single bank is read while being written.
// ============================================================================
module apple_video_fetch (
    input  logic        clk_logic,
    input  logic        reset,
    input  logic        line_start_i,
    input  logic [7:0]  line_i,
    input  logic        text_mode_i,
    input  logic        mixed_mode_i,
    input  logic        hires_mode_i,
    input  logic        page2_i,
    input  logic        store80_i,
    output logic [15:0] video_address_o,
    output logic        video_rd_o,
    input  logic [31:0] video_data_i,
    input  logic [4:0]  buf_addr_i,
    output logic [31:0] buf_data_o,
    output logic        busy_o,
    output logic        line_done_o,
    output logic        overrun_o,
    output logic        is_text_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [4:0] c_LAST_WORD = 5'd19;

`ifdef APPLE_VIDEO_FETCH_DOUBLE_BUFFER_EN
    localparam int c_BUF_WORDS = 40;
    localparam int c_IDX_W     = 6;
`else
    localparam int c_BUF_WORDS = 20;
    localparam int c_IDX_W     = 5;
`endif

    logic [1:0]          r_state;
    logic [4:0]          r_count;
    logic [15:0]         r_addr;
    logic                r_rd;
    logic                r_busy;
    logic                r_done;
    logic                r_overrun;
    logic                r_is_text;
    logic                r_text_latched;
    logic                r_rd_d;
    logic [4:0]          r_idx_d;
    logic [31:0]         r_buf [0:c_BUF_WORDS-1];
`ifdef APPLE_VIDEO_FETCH_DOUBLE_BUFFER_EN
    logic                r_wbank;
`endif

    logic                w_line_ok;
    logic                w_page2;
    logic                w_text;
    logic [15:0]         w_text_base;
    logic [15:0]         w_hires_base;
    logic [c_IDX_W-1:0]  w_rd_index;
    logic [c_IDX_W-1:0]  w_wr_index;

    assign w_line_ok = (line_i < 8'd192);
    assign w_page2   = page2_i & ~store80_i;
    assign w_text    = text_mode_i | (mixed_mode_i & (line_i >= 8'd160)) | ~hires_mode_i;

    // Text rows: r = line/8, so r mod 8 = line[5:3] and r div 8 = line[7:6].
    assign w_text_base  = 16'h0400
                        + (16'(line_i[5:3]) << 7)
                        + 16'(line_i[7:6]) * 16'd40
                        + (w_page2 ? 16'h0400 : 16'h0000);
    assign w_hires_base = 16'h2000
                        + (16'(line_i[2:0]) << 10)
                        + (16'(line_i[5:3]) << 7)
                        + 16'(line_i[7:6]) * 16'd40
                        + (w_page2 ? 16'h2000 : 16'h0000);

`ifdef APPLE_VIDEO_FETCH_DOUBLE_BUFFER_EN
    assign w_rd_index = (r_wbank ? 6'd0 : 6'd20) + {1'b0, buf_addr_i};
    assign w_wr_index = (r_wbank ? 6'd20 : 6'd0) + {1'b0, r_idx_d};
`else
    assign w_rd_index = buf_addr_i;
    assign w_wr_index = r_idx_d;
`endif

    always_ff @(posedge clk_logic or posedge reset) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_count        <= 5'd0;
            r_addr         <= 16'h0000;
            r_rd           <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_overrun      <= 1'b0;
            r_is_text      <= 1'b0;
            r_text_latched <= 1'b0;
            r_rd_d         <= 1'b0;
            r_idx_d        <= 5'd0;
`ifdef APPLE_VIDEO_FETCH_DOUBLE_BUFFER_EN
            r_wbank        <= 1'b0;
`endif
        end else begin
            r_done  <= 1'b0;
            // Read data returns one cycle after the strobe, so the capture
            // slot trails the read slot by one cycle.
            r_rd_d  <= r_rd;
            r_idx_d <= r_count;

            if (line_start_i && w_line_ok && r_busy) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (line_start_i && w_line_ok) begin
                        r_state        <= c_ISSUE;
                        r_busy         <= 1'b1;
                        r_rd           <= 1'b1;
                        r_count        <= 5'd0;
                        r_addr         <= w_text ? w_text_base : w_hires_base;
                        r_text_latched <= w_text;
                    end
                end
                c_ISSUE: begin
                    if (r_count == c_LAST_WORD) begin
                        r_state <= c_DRAIN;
                        r_rd    <= 1'b0;
                    end else begin
                        r_count <= r_count + 5'd1;
                        r_addr  <= r_addr + 16'd2;
                    end
                end
                c_DRAIN: begin
                    // Last word lands on this edge, so the finished line is
                    // readable from the DONE cycle onward.
                    r_state   <= c_DONE;
                    r_done    <= 1'b1;
                    r_is_text <= r_text_latched;
`ifdef APPLE_VIDEO_FETCH_DOUBLE_BUFFER_EN
                    r_wbank   <= ~r_wbank;
`endif
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_rd    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_logic or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_BUF_WORDS; i++) begin
                r_buf[i] <= 32'h0;
            end
        end else if (r_rd_d) begin
            r_buf[w_wr_index] <= video_data_i;
        end
    end

    always_comb begin
        buf_data_o = 32'h0;
        if (buf_addr_i <= c_LAST_WORD) begin
            buf_data_o = r_buf[w_rd_index];
        end
    end

    assign video_address_o = r_addr;
    assign video_rd_o      = r_rd;
    assign busy_o          = r_busy;
    assign line_done_o     = r_done;
    assign overrun_o       = r_overrun;
    assign is_text_o       = r_is_text;

endmodule
`default_nettype wire
